// File: rtl/fetch_queue.sv
// Sequential-PC fetch front end: issues imem requests, buffers in-order responses, feeds decode.
// Response->decode latency 1 cycle; requests stall when buffered + live in-flight would exceed DEPTH.
module fetch_queue #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 4
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    output logic        dec_valid,
    input  logic        dec_ready,
    output logic [31:0] dec_instr,
    output logic [31:0] dec_pc,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int IW = PW + 2;
    localparam int SD = 2 * DEPTH;
    localparam int SW = PW + 1;
    localparam logic [IW:0]   DEPTH_C = (IW+1)'(DEPTH);
    localparam logic [IW-1:0] INF_MAX = IW'(2 * DEPTH);

    logic [31:0]   pc_q, pc_d;
    logic [CW-1:0] count_q, count_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [IW-1:0] inflight_q, inflight_d;
    logic [IW-1:0] drop_cnt_q, drop_cnt_d;
    logic [SW-1:0] sq_rd_q, sq_rd_d, sq_wr_q, sq_wr_d;

    logic [31:0] fifo_instr_q [DEPTH];
    logic [31:0] fifo_pc_q    [DEPTH];
    // Holds the PC of every outstanding request, stale ones included, so it is
    // sized to the in-flight cap rather than the FIFO depth.
    logic [31:0] sq_pc_q      [SD];

    logic          req_fire, push, pop;
    logic [IW:0]   credit_used;

    assign credit_used    = {2'b00, count_q} + {1'b0, inflight_q} - {1'b0, drop_cnt_q};
    assign imem_req_valid = ~rst & ~redirect_valid & (credit_used < DEPTH_C) & (inflight_q < INF_MAX);
    assign imem_req_addr  = pc_q;
    assign dec_valid      = (count_q != '0) & ~redirect_valid;
    assign dec_instr      = fifo_instr_q[rd_ptr_q];
    assign dec_pc         = fifo_pc_q[rd_ptr_q];

    assign req_fire = imem_req_valid & imem_req_ready;
    assign pop      = dec_valid & dec_ready;
    assign push     = imem_resp_valid & ~redirect_valid & (drop_cnt_q == '0);

    always_comb begin
        pc_d       = pc_q;
        count_d    = count_q + CW'(push) - CW'(pop);
        rd_ptr_d   = rd_ptr_q + PW'(pop);
        wr_ptr_d   = wr_ptr_q + PW'(push);
        inflight_d = inflight_q + IW'(req_fire) - IW'(imem_resp_valid);
        drop_cnt_d = drop_cnt_q;
        sq_wr_d    = sq_wr_q + SW'(req_fire);
        sq_rd_d    = sq_rd_q + SW'(imem_resp_valid);

        if (req_fire)
            pc_d = pc_q + 32'd4;
        if (imem_resp_valid && drop_cnt_q != '0)
            drop_cnt_d = drop_cnt_q - 1'b1;

        if (redirect_valid) begin
            pc_d       = redirect_pc & 32'hFFFF_FFFC;
            count_d    = '0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            drop_cnt_d = inflight_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q       <= RESET_PC;
            count_q    <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            inflight_q <= '0;
            drop_cnt_q <= '0;
            sq_rd_q    <= '0;
            sq_wr_q    <= '0;
        end else begin
            pc_q       <= pc_d;
            count_q    <= count_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            inflight_q <= inflight_d;
            drop_cnt_q <= drop_cnt_d;
            sq_rd_q    <= sq_rd_d;
            sq_wr_q    <= sq_wr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_instr_q[wr_ptr_q] <= imem_resp_data;
            fifo_pc_q[wr_ptr_q]    <= sq_pc_q[sq_rd_q];
        end
        if (req_fire)
            sq_pc_q[sq_wr_q] <= pc_q;
    end

    // Credits should make a live push into a full FIFO impossible.
    always_ff @(posedge clk) begin
        if (!rst && push && !pop)
            assert (count_q != CW'(DEPTH));
    end
endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue with an in-order, fixed-latency instruction memory model.
module tb_fetch_queue;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req_valid, imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        dec_valid, dec_ready;
    logic [31:0] dec_instr, dec_pc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    fetch_queue #(.RESET_PC(32'h0000_0000), .DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
        .dec_valid(dec_valid), .dec_ready(dec_ready),
        .dec_instr(dec_instr), .dec_pc(dec_pc),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    int lat   = 1;
    logic rst_nx = 1'b1;

    logic [31:0] mq_addr [$];
    int          mq_due  [$];
    logic [31:0] req_log [$];
    logic [31:0] pop_pc  [$];
    logic [31:0] pop_ins [$];

    logic        s_req_v, s_dec_v;
    logic [31:0] s_req_a, s_dec_pc, s_dec_ins;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return a ^ 32'hDEAD_0000;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock cycle: apply inputs after the edge, then sample and update the models.
    task automatic cycle(input logic rv = 1'b0, input logic [31:0] rpc = 32'h0, input logic drdy = 1'b1);
        @(posedge clk);
        #1;
        rst            = rst_nx;
        redirect_valid = rv;
        redirect_pc    = rpc;
        dec_ready      = drdy;
        imem_req_ready = 1'b1;
        if (mq_addr.size() > 0 && mq_due[0] <= cyc) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = instr_of(mq_addr[0]);
            void'(mq_addr.pop_front());
            void'(mq_due.pop_front());
        end else begin
            imem_resp_valid = 1'b0;
            imem_resp_data  = 32'h0;
        end
        #1;
        s_req_v   = imem_req_valid;
        s_req_a   = imem_req_addr;
        s_dec_v   = dec_valid;
        s_dec_pc  = dec_pc;
        s_dec_ins = dec_instr;
        if (imem_req_valid && imem_req_ready) begin
            mq_addr.push_back(imem_req_addr);
            mq_due.push_back(cyc + lat);
            req_log.push_back(imem_req_addr);
        end
        if (dec_valid && dec_ready) begin
            pop_pc.push_back(dec_pc);
            pop_ins.push_back(dec_instr);
        end
        cyc++;
    endtask

    task automatic do_reset();
        rst_nx = 1'b1;
        cycle();
        chk("rst_req_valid", {31'b0, s_req_v}, 32'd0);
        rst_nx = 1'b0;
        mq_addr.delete();
        mq_due.delete();
        req_log.delete();
        pop_pc.delete();
        pop_ins.delete();
        cyc = 0;
    endtask

    initial begin
        imem_req_ready  = 1'b1;
        imem_resp_valid = 1'b0;
        imem_resp_data  = 32'h0;
        dec_ready       = 1'b1;
        redirect_valid  = 1'b0;
        redirect_pc     = 32'h0;

        // Latency 1, decode always ready: one instruction per cycle after 2 cycles.
        lat = 1;
        do_reset();
        for (int k = 0; k < 8; k++) begin
            cycle();
            chk("seq_req_valid", {31'b0, s_req_v}, 32'd1);
            chk("seq_req_addr", s_req_a, 32'(4 * k));
            if (k < 2) begin
                chk("seq_dec_valid_early", {31'b0, s_dec_v}, 32'd0);
            end else begin
                chk("seq_dec_valid", {31'b0, s_dec_v}, 32'd1);
                chk("seq_dec_pc", s_dec_pc, 32'(4 * (k - 2)));
                chk("seq_dec_instr", s_dec_ins, instr_of(32'(4 * (k - 2))));
            end
        end

        // Back-pressure: exactly DEPTH requests, then drain in order and resume at 0x10.
        lat = 2;
        do_reset();
        for (int k = 0; k < 10; k++) cycle(1'b0, 32'h0, 1'b0);
        chk("bp_req_count", 32'(req_log.size()), 32'd4);
        chk("bp_last_addr", req_log[3], 32'h0000_000C);
        chk("bp_req_valid_off", {31'b0, s_req_v}, 32'd0);
        chk("bp_dec_valid", {31'b0, s_dec_v}, 32'd1);
        chk("bp_head_pc", s_dec_pc, 32'h0);
        for (int k = 0; k < 6; k++) cycle();
        chk("bp_pop_count", 32'(pop_pc.size()), 32'd6);
        chk("bp_pop0", pop_pc[0], 32'h0);
        chk("bp_pop1", pop_pc[1], 32'h4);
        chk("bp_pop2", pop_pc[2], 32'h8);
        chk("bp_pop3", pop_pc[3], 32'hC);
        chk("bp_pop3_instr", pop_ins[3], instr_of(32'hC));
        chk("bp_pop4", pop_pc[4], 32'h10);
        chk("bp_resume_addr", req_log[4], 32'h10);

        // Latency 3, redirect with three requests outstanding.
        lat = 3;
        do_reset();
        for (int k = 0; k < 3; k++) cycle();
        cycle(1'b1, 32'h0000_0100);
        chk("rd1_dec_valid", {31'b0, s_dec_v}, 32'd0);
        chk("rd1_req_valid", {31'b0, s_req_v}, 32'd0);
        for (int k = 0; k < 8; k++) cycle();
        chk("rd1_first_req", req_log[3], 32'h100);
        chk("rd1_pop_count", 32'(pop_pc.size()), 32'd4);
        chk("rd1_pop0_pc", pop_pc[0], 32'h100);
        chk("rd1_pop0_instr", pop_ins[0], instr_of(32'h100));
        chk("rd1_pop1_pc", pop_pc[1], 32'h104);

        // Redirect to 0x203 with a response arriving that cycle and two entries buffered.
        lat = 1;
        do_reset();
        for (int k = 0; k < 3; k++) cycle(1'b0, 32'h0, 1'b0);
        cycle(1'b1, 32'h0000_0203);
        chk("rd2_dec_valid", {31'b0, s_dec_v}, 32'd0);
        cycle();
        chk("rd2_flushed", {31'b0, s_dec_v}, 32'd0);
        chk("rd2_req_addr", s_req_a, 32'h200);
        for (int k = 0; k < 3; k++) cycle();
        chk("rd2_pop0_pc", pop_pc[0], 32'h200);
        chk("rd2_pop0_instr", pop_ins[0], instr_of(32'h200));

        // Back-to-back redirects: last one wins, nothing from 0x40 is fetched or delivered.
        lat = 2;
        do_reset();
        cycle();
        cycle();
        cycle(1'b1, 32'h0000_0040);
        cycle(1'b1, 32'h0000_0080);
        chk("rd3_dec_valid", {31'b0, s_dec_v}, 32'd0);
        for (int k = 0; k < 5; k++) cycle();
        chk("rd3_first_req", req_log[2], 32'h80);
        chk("rd3_pop0_pc", pop_pc[0], 32'h80);
        chk("rd3_pop0_instr", pop_ins[0], instr_of(32'h80));
        chk("rd3_pop1_pc", pop_pc[1], 32'h84);

        // PC wrap, then reset in mid-stream.
        lat = 1;
        do_reset();
        cycle(1'b1, 32'hFFFF_FFFC);
        cycle();
        chk("wrap_req_hi", s_req_a, 32'hFFFF_FFFC);
        cycle();
        chk("wrap_req_lo", s_req_a, 32'h0);
        cycle();
        cycle();
        chk("wrap_pop0", pop_pc[0], 32'hFFFF_FFFC);
        chk("wrap_pop1", pop_pc[1], 32'h0);
        chk("wrap_pop1_instr", pop_ins[1], instr_of(32'h0));
        chk("pre_rst_dec_valid", {31'b0, s_dec_v}, 32'd1);
        do_reset();
        cycle();
        chk("post_rst_req_valid", {31'b0, s_req_v}, 32'd1);
        chk("post_rst_req_addr", s_req_a, 32'h0);
        chk("post_rst_dec_valid", {31'b0, s_dec_v}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
